// File: rtl/bus_master_req.sv
// Bus initiator for one master port of the shared bus: requests the bus, runs a burst of
// single-cycle reads or writes at consecutive addresses, then releases the bus.
module bus_master_req #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              op_wr,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] seed,
  input  logic              m_grant,
  input  logic [DATA_W-1:0] m_din,
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_sum
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StXfer = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0] rd_sum_q, rd_sum_d;
  logic              last_beat;
  logic              in_xfer;

  // len - 1 wraps to all ones for len == 0, giving the full 2^LEN_W beat burst.
  assign last_beat = (beat_q == (len_q - LEN_W'(1)));
  assign in_xfer   = (state_q == StXfer);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    base_d   = base_q;
    len_d    = len_q;
    seed_d   = seed_q;
    beat_d   = beat_q;
    rd_sum_d = rd_sum_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StReq;
          op_d     = op_wr;
          base_d   = base_addr;
          len_d    = len;
          seed_d   = seed;
          beat_d   = '0;
          rd_sum_d = '0;
        end
      end
      StReq: begin
        if (m_grant) state_d = StXfer;
      end
      StXfer: begin
        if (m_grant) begin
          beat_d = beat_q + LEN_W'(1);
          if (!op_q) rd_sum_d = rd_sum_q + m_din;
          if (last_beat) state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      op_q     <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      seed_q   <= '0;
      beat_q   <= '0;
      rd_sum_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      base_q   <= base_d;
      len_q    <= len_d;
      seed_q   <= seed_d;
      beat_q   <= beat_d;
      rd_sum_q <= rd_sum_d;
    end
  end

  // Bus drive is decoded from state so reset removes the request without waiting for an edge.
  assign m_req  = (state_q == StReq) || in_xfer;
  assign m_wr   = in_xfer && op_q && m_grant;
  assign m_addr = in_xfer ? (base_q + ADDR_W'(beat_q)) : '0;
  assign m_dout = (in_xfer && op_q) ? (seed_q + DATA_W'(beat_q)) : '0;
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign rd_sum = rd_sum_q;

endmodule

// File: tb/tb_bus_master_req.sv
// Bench for bus_master_req: directed burst table, reset corner cases, then random bursts
// checked cycle by cycle against a beat-list model of the burst.
module tb_bus_master_req;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op_wr = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [3:0]  len = '0;
  logic [31:0] seed = '0;
  logic        m_grant = 1'b0;
  logic [31:0] m_din;
  logic        m_req, m_wr, busy, done;
  logic [7:0]  m_addr;
  logic [31:0] m_dout, rd_sum;
  logic [31:0] din_salt = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Bus-side memory model: read data is a simple function of the address.
  assign m_din = 32'(m_addr) * 32'd2 + din_salt;

  bus_master_req #(.ADDR_W(8), .DATA_W(32), .LEN_W(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op_wr    (op_wr),
    .base_addr(base_addr),
    .len      (len),
    .seed     (seed),
    .m_grant  (m_grant),
    .m_din    (m_din),
    .m_req    (m_req),
    .m_wr     (m_wr),
    .m_addr   (m_addr),
    .m_dout   (m_dout),
    .busy     (busy),
    .done     (done),
    .rd_sum   (rd_sum)
  );

  typedef struct {
    bit          op;
    logic [7:0]  base;
    logic [3:0]  len;
    logic [31:0] seed;
    logic [63:0] stall;     // bit i set: grant low in cycle i after start
    logic [63:0] noise;     // bit i set: start pulsed in cycle i after start
    logic [31:0] exp_sum;
    int          exp_done;  // cycle index (after start edge) of the done pulse
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v, input bit rnd, output int done_at,
                           output logic [31:0] final_sum);
    int          nbeats;
    int          bd;
    bit          entered;
    bit          fin;
    bit          g;
    logic [31:0] sum;
    logic        e_req, e_wr, e_busy, e_done;
    logic [7:0]  e_addr;
    logic [31:0] e_dout;
    nbeats  = (v.len == 4'd0) ? 16 : int'(v.len);
    bd      = 0;
    entered = 1'b0;
    fin     = 1'b0;
    sum     = '0;
    done_at = -1;
    @(negedge clk);
    start     = 1'b1;
    op_wr     = v.op;
    base_addr = v.base;
    len       = v.len;
    seed      = v.seed;
    m_grant   = rnd ? 1'($urandom_range(1)) : 1'b1;
    for (int i = 1; i <= 200 && !fin; i++) begin
      @(negedge clk);
      start     = rnd ? ($urandom_range(5) == 0) : (i < 64 && v.noise[i]);
      op_wr     = 1'($urandom);
      base_addr = 8'($urandom);
      len       = 4'($urandom);
      seed      = $urandom;
      g         = rnd ? ($urandom_range(99) < 70) : !(i < 64 && v.stall[i]);
      m_grant   = g;
      #1;
      e_req = 1'b0; e_wr = 1'b0; e_busy = 1'b1; e_done = 1'b0; e_addr = '0; e_dout = '0;
      if (!entered) begin
        e_req = 1'b1;
      end else if (bd < nbeats) begin
        e_req  = 1'b1;
        e_addr = 8'(v.base + 8'(bd));
        e_wr   = v.op & g;
        e_dout = v.op ? (v.seed + 32'(bd)) : 32'd0;
      end else begin
        e_done = 1'b1;
      end
      chk("m_req", 32'(m_req), 32'(e_req));
      chk("m_wr", 32'(m_wr), 32'(e_wr));
      chk("m_addr", 32'(m_addr), 32'(e_addr));
      chk("m_dout", m_dout, e_dout);
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("rd_sum_run", rd_sum, sum);
      if (!entered) begin
        if (g) entered = 1'b1;
      end else if (bd < nbeats) begin
        if (g) begin
          if (!v.op) sum += 32'(e_addr) * 32'd2 + din_salt;
          bd++;
        end
      end else begin
        fin     = 1'b1;
        done_at = i;
      end
    end
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL burst_timeout: no done within 200 cycles, required done");
    end
    @(negedge clk);
    start   = 1'b0;
    m_grant = 1'b1;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_req", 32'(m_req), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_sum", rd_sum, sum);
    final_sum = rd_sum;
  endtask

  initial begin
    int          d_at;
    logic [31:0] fsum;
    vec_t        rv;

    vecs[0] = '{1'b1, 8'h10, 4'd4, 32'h100, 64'h0, 64'h0, 32'h0, 6};
    vecs[1] = '{1'b0, 8'hFE, 4'd3, 32'h55, 64'h0, 64'h0, 32'h3FA, 5};
    vecs[2] = '{1'b1, 8'h20, 4'd4, 32'hA0, 64'h3E, 64'h0, 32'h0, 11};
    vecs[3] = '{1'b1, 8'h10, 4'd4, 32'h100, 64'h18, 64'h0, 32'h0, 8};
    vecs[4] = '{1'b0, 8'h40, 4'd0, 32'h0, 64'h0, 64'h0, 32'h8F0, 18};
    vecs[5] = '{1'b0, 8'h80, 4'd2, 32'h0, 64'h0, 64'h1C, 32'h202, 4};
    vecs[6] = '{1'b1, 8'hF8, 4'd0, 32'hFFFF_FFF8, 64'h0, 64'h0, 32'h0, 18};

    // Power-up reset
    m_grant = 1'b1;
    #1;
    chk("por_req", 32'(m_req), 32'd0);
    chk("por_busy", 32'(busy), 32'd0);
    chk("por_addr", 32'(m_addr), 32'd0);
    chk("por_sum", rd_sum, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("idle_grant_req", 32'(m_req), 32'd0);
      chk("idle_grant_done", 32'(done), 32'd0);
    end

    din_salt = '0;
    for (int k = 0; k < 7; k++) begin
      run_burst(vecs[k], 1'b0, d_at, fsum);
      chk($sformatf("vec%0d_done_cycle", k), 32'(d_at), 32'(vecs[k].exp_done));
      chk($sformatf("vec%0d_rd_sum", k), fsum, vecs[k].exp_sum);
    end

    // Reset during the third beat of a read burst
    @(negedge clk);
    start = 1'b1; op_wr = 1'b0; base_addr = 8'h30; len = 4'd4; seed = '0; m_grant = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pre_addr", 32'(m_addr), 32'h32);
    chk("rst_pre_sum", rd_sum, 32'hC2);
    reset_n = 1'b0;
    #1;
    chk("rst_req", 32'(m_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(m_addr), 32'd0);
    chk("rst_wr", 32'(m_wr), 32'd0);
    chk("rst_sum", rd_sum, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_req", 32'(m_req), 32'd0);
      chk("post_rst_done", 32'(done), 32'd0);
    end

    // Random bursts with random grant gaps and stray start pulses
    for (int k = 0; k < 40; k++) begin
      rv.op       = 1'($urandom);
      rv.base     = 8'($urandom);
      rv.len      = 4'($urandom);
      rv.seed     = $urandom;
      rv.stall    = '0;
      rv.noise    = '0;
      rv.exp_sum  = '0;
      rv.exp_done = 0;
      din_salt    = $urandom;
      run_burst(rv, 1'b1, d_at, fsum);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_master_req.md
Name: bus_master_req

Overview:
- Bus-initiator block that sits on one master port (m0 or m1) of the two-master shared bus, on the far side of the bus arbiter.
- Requests ownership with a level req, waits for grant, then performs a burst of single-cycle reads or writes at consecutive addresses. It releases the bus when the burst completes.
- Supplies incrementing write data and accumulates a running sum of read data for the host.

Parameters:
ADDR_W, 8, bus address width
DATA_W, 32, bus data width
LEN_W, 4, burst length field width; length 0 encodes 2^LEN_W beats

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  reset, asynchronous, active-low
start  in  1  host command strobe; sampled only in IDLE
op_wr  in  1  1 = write burst, 0 = read burst
base_addr  in  ADDR_W  first beat address
len  in  LEN_W  beat count (0 -> 16 beats at default)
seed  in  DATA_W  write data for beat 0
m_grant  in  1  grant from bus arbiter
m_din  in  DATA_W  read data from bus, valid in the same cycle as m_addr
m_req  out  1  bus request to arbiter
m_wr  out  1  write enable to bus
m_addr  out  ADDR_W  bus address
m_dout  out  DATA_W  bus write data
busy  out  1  high in REQ, XFER and DONE
done  out  1  one-cycle pulse at burst end
rd_sum  out  DATA_W  sum of read beats of last burst

Behaviour:
- Reset (async, reset_n=0): state IDLE; m_req, m_wr, busy, done = 0; m_addr, m_dout, rd_sum = 0; internal op/base/len/seed/beat registers = 0. Reset mid-burst abandons the transfer, and m_req drops immediately.
- States: IDLE, REQ, XFER, DONE.
- IDLE -> REQ: on an edge with start=1. The same edge latches op_wr, base_addr, len, seed, clears beat index and clears rd_sum. start is ignored in every other state.
- REQ: m_req=1, no bus drive. REQ -> XFER on an edge with m_grant=1. Grant seen while m_req=0 (arbiter parked on this port) is ignored.
- XFER: m_req=1.
  - m_addr = base + beat, mod 2^ADDR_W (wraps FF->00).
  - m_dout = seed + beat, mod 2^DATA_W, when op=write; otherwise 0.
  - m_wr = op & m_grant.
  - A beat completes on each edge with m_grant=1. On that edge the beat index increments, and on a read rd_sum += m_din, mod 2^DATA_W.
  - If m_grant=0 the cycle stalls: beat index, address and rd_sum hold, m_wr=0, m_req stays 1.
- XFER -> DONE: on the edge completing the last beat (beat = len-1, or 2^LEN_W-1 when len=0).
- DONE: m_req=0, done=1 for exactly one cycle, busy=1. DONE -> IDLE unconditionally.
- m_addr and m_dout are 0 outside XFER.
- Latency with grant already high:
  - start edge E0 -> m_req high after E0.
  - Grant sampled at E1 -> XFER.
  - N beats on edges E2..E(N+1).
  - done high during the cycle after E(N+1).
  - Total N+3 cycles from start to IDLE.
- rd_sum holds its value after DONE until the next start. A write burst leaves rd_sum=0.
- All outputs are registered, or decoded from state plus m_grant. No other combinational paths from inputs.

Test Plan:
1. Reset: assert reset_n=0 mid-cycle -> all outputs 0 immediately. Release, idle 3 cycles -> m_req stays 0 even with m_grant=1.
2. Write burst, grant tied 1: base=0x10, len=4, seed=0x100, op_wr=1 -> m_req rises 1 cycle after start. m_wr high exactly 4 cycles with addr 0x10..0x13 and dout 0x100..0x103. done pulses once, 6 cycles after start.
3. Read wrap: base=0xFE, len=3, m_din=2*m_addr -> addresses 0xFE, 0xFF, 0x00, and rd_sum=0x3FA after done. m_wr never high.
4. Delayed grant: m_grant=0 for 5 cycles after start, then 1 -> m_req held high throughout, no m_addr/m_wr activity until grant, then normal 4-beat burst.
5. Grant drop: write len=4, drop m_grant for 2 cycles after beat 1 -> addr holds 0x11 with m_wr=0 during the drop. Exactly 4 writes total with correct data, done follows the 4th.
6. len=0 -> 16 beats (addr base..base+15).
7. start pulsed during XFER -> ignored, with no change to latched base.
8. reset_n low during beat 3 -> m_req=0 asynchronously, state IDLE, no done pulse.
